// File: rtl/buzzer_arbiter_if.sv
// buzzer_arbiter_if: request/status bundle between the keypad controller (master) and the buzzer arbiter (slave)
// Signals: req_click/req_ok/req_err one-cycle pulses, alarm_en level, buzzer pin drive, busy, tone_id, done pulse.
interface buzzer_arbiter_if;
  logic       req_click;
  logic       req_ok;
  logic       req_err;
  logic       alarm_en;
  logic       buzzer;
  logic       busy;
  logic [2:0] tone_id;
  logic       done;
  modport master (output req_click, req_ok, req_err, alarm_en, input buzzer, busy, tone_id, done);
  modport slave  (input req_click, req_ok, req_err, alarm_en, output buzzer, busy, tone_id, done);
endinterface

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: fixed-priority, preemptive sequencer of four tone patterns onto the single piezo pin
// Ports: clk (rising edge), RST (asynchronous, active-high), bus (slave side of buzzer_arbiter_if):
//   in  req_click/req_ok/req_err (pulses), alarm_en (level)
//   out buzzer (pin), busy (not idle), tone_id (0 idle,1 click,2 ok,3 err,4 alarm), done (natural end pulse)
module buzzer_arbiter #(
  parameter int CNT_W      = 32,
  parameter int CLICK_HALF = 50000,
  parameter int CLICK_LEN  = 10000000,
  parameter int OK_HALF    = 25000,
  parameter int OK_LEN     = 30000000,
  parameter int ERR_HALF   = 100000,
  parameter int ERR_SEG    = 5000000,
  parameter int ALM_HALF   = 12500,
  parameter int ALM_SEG    = 2500000
) (
  input logic             clk,
  input logic             RST,
  buzzer_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLICK, OK, ERR_ON1, ERR_GAP, ERR_ON2, ALM_ON, ALM_OFF} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d, tone_q, tone_d, half_m1, len_m1;
  logic             buzzer_q, buzzer_d, busy_q, busy_d, done_q, done_d;
  logic [2:0]       tone_id_q, tone_id_d, cls_q, req_cls;
  logic             enter, tc, wrap, on_q;
  // Class doubles as priority rank and as the tone_id reported for a state.
  function automatic logic [2:0] cls(input state_t s);
    return s == IDLE ? 3'd0 : s == CLICK ? 3'd1 : s == OK ? 3'd2 :
           (s == ALM_ON || s == ALM_OFF) ? 3'd4 : 3'd3;
  endfunction
  function automatic logic is_on(input state_t s);
    return s == CLICK || s == OK || s == ERR_ON1 || s == ERR_ON2 || s == ALM_ON;
  endfunction
  always_comb begin
    cls_q   = cls(state_q);
    on_q    = is_on(state_q);
    req_cls = bus.req_err ? 3'd3 : bus.req_ok ? 3'd2 : bus.req_click ? 3'd1 : 3'd0;
    half_m1 = cls_q == 3'd1 ? CNT_W'(CLICK_HALF - 1) : cls_q == 3'd2 ? CNT_W'(OK_HALF - 1) :
              cls_q == 3'd3 ? CNT_W'(ERR_HALF - 1) : CNT_W'(ALM_HALF - 1);
    len_m1  = cls_q == 3'd1 ? CNT_W'(CLICK_LEN - 1) : cls_q == 3'd2 ? CNT_W'(OK_LEN - 1) :
              cls_q == 3'd3 ? CNT_W'(ERR_SEG - 1) : CNT_W'(ALM_SEG - 1);
    tc      = dur_q == len_m1;
    wrap    = tone_q == half_m1;
    // enter: a state is (re)entered this edge, so both counters clear; idle also holds them at zero
    state_d = state_q;
    enter   = 1'b1;
    done_d  = 1'b0;
    if (cls_q == 3'd4) begin
      if (!bus.alarm_en) state_d = IDLE;
      else if (tc) state_d = state_q == ALM_ON ? ALM_OFF : ALM_ON;
      else enter = 1'b0;
    end else if (bus.alarm_en) state_d = ALM_ON;
    // Requests win over the terminal-count advance, so a same-class retrigger there suppresses done.
    else if (req_cls != 3'd0 && req_cls >= cls_q)
      state_d = req_cls == 3'd3 ? ERR_ON1 : req_cls == 3'd2 ? OK : CLICK;
    else if (tc && state_q != IDLE) begin
      state_d = state_q == ERR_ON1 ? ERR_GAP : state_q == ERR_GAP ? ERR_ON2 : IDLE;
      done_d  = state_q == CLICK || state_q == OK || state_q == ERR_ON2;
    end else enter = state_q == IDLE;
    dur_d     = enter ? '0 : dur_q + CNT_W'(1);
    tone_d    = (enter || !on_q || wrap) ? '0 : tone_q + CNT_W'(1);
    buzzer_d  = enter ? is_on(state_d) : on_q && (buzzer_q ^ wrap);
    busy_d    = state_d != IDLE;
    tone_id_d = cls(state_d);
  end
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      tone_q    <= '0;
      buzzer_q  <= 1'b0;
      busy_q    <= 1'b0;
      tone_id_q <= 3'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      tone_q    <= tone_d;
      buzzer_q  <= buzzer_d;
      busy_q    <= busy_d;
      tone_id_q <= tone_id_d;
      done_q    <= done_d;
    end
  assign bus.buzzer  = buzzer_q;
  assign bus.busy    = busy_q;
  assign bus.tone_id = tone_id_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed self-checking bench for buzzer_arbiter with HALF=2, LEN/SEG=12
module tb_buzzer_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [5:0] o;
  buzzer_arbiter_if bus();
  buzzer_arbiter #(
    .CNT_W(32), .CLICK_HALF(2), .CLICK_LEN(12), .OK_HALF(2), .OK_LEN(12),
    .ERR_HALF(2), .ERR_SEG(12), .ALM_HALF(2), .ALM_SEG(12)
  ) dut (.clk(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  // observed outputs packed as {buzzer, busy, tone_id, done}
  assign o = {bus.buzzer, bus.busy, bus.tone_id, bus.done};
  function automatic logic [5:0] ev(input logic b, input logic [2:0] id, input logic d);
    return {b, id != 3'd0, id, d};
  endfunction
  // square wave with half-period 2, high half first
  function automatic logic tone(input int j);
    return (j % 4) < 2;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL reset_async got %b exp %b", o, 6'b0); end
    tick();
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL reset_held got %b exp %b", o, 6'b0); end
    rst = 1'b0;
    tick();
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL reset_idle got %b exp %b", o, 6'b0); end
  endtask
  task automatic test_click();
    logic [5:0] e;
    bus.req_click = 1'b1; tick(); bus.req_click = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = ev(tone(i), 3'd1, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL click c%0d got %b exp %b", i, o, e); end
      tick();
    end
    checks++; if (o !== ev(1'b0, 3'd0, 1'b1)) begin errors++; $display("FAIL click_done got %b exp %b", o, ev(1'b0, 3'd0, 1'b1)); end
    tick();
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL click_idle got %b exp %b", o, 6'b0); end
  endtask
  task automatic test_err();
    logic [5:0] e;
    bus.req_err = 1'b1; tick(); bus.req_err = 1'b0;
    for (int i = 0; i < 36; i++) begin
      e = ev(i / 12 == 1 ? 1'b0 : tone(i % 12), 3'd3, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL err c%0d got %b exp %b", i, o, e); end
      tick();
    end
    checks++; if (o !== ev(1'b0, 3'd0, 1'b1)) begin errors++; $display("FAIL err_done got %b exp %b", o, ev(1'b0, 3'd0, 1'b1)); end
    tick();
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL err_idle got %b exp %b", o, 6'b0); end
  endtask
  task automatic test_priority();
    logic [5:0] e;
    bus.req_click = 1'b1; bus.req_ok = 1'b1; tick(); bus.req_click = 1'b0; bus.req_ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = ev(tone(i), 3'd2, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL ok c%0d got %b exp %b", i, o, e); end
      bus.req_click = (i == 5);
      tick();
    end
    bus.req_click = 1'b0;
    checks++; if (o !== ev(1'b0, 3'd0, 1'b1)) begin errors++; $display("FAIL ok_done got %b exp %b", o, ev(1'b0, 3'd0, 1'b1)); end
    tick();
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL ok_idle got %b exp %b", o, 6'b0); end
  endtask
  task automatic test_preempt();
    logic [5:0] e;
    bus.req_ok = 1'b1; tick(); bus.req_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = ev(tone(i), 3'd2, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL pre_ok c%0d got %b exp %b", i, o, e); end
      bus.req_err = (i == 4);
      tick();
    end
    bus.req_err = 1'b0;
    for (int i = 0; i < 36; i++) begin
      e = ev(i / 12 == 1 ? 1'b0 : tone(i % 12), 3'd3, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL pre_err c%0d got %b exp %b", i, o, e); end
      tick();
    end
    checks++; if (o !== ev(1'b0, 3'd0, 1'b1)) begin errors++; $display("FAIL pre_done got %b exp %b", o, ev(1'b0, 3'd0, 1'b1)); end
    tick();
  endtask
  task automatic test_alarm();
    logic [5:0] e;
    bus.req_click = 1'b1; tick(); bus.req_click = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = ev(tone(i), 3'd1, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL alm_click c%0d got %b exp %b", i, o, e); end
      tick();
    end
    bus.alarm_en = 1'b1; tick();
    for (int i = 0; i <= 40; i++) begin
      e = ev((i / 12) % 2 == 0 ? tone(i % 12) : 1'b0, 3'd4, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL alarm c%0d got %b exp %b", i, o, e); end
      bus.req_err = (i == 20);
      if (i == 40) bus.alarm_en = 1'b0;
      tick();
    end
    bus.req_err = 1'b0;
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL alarm_off got %b exp %b", o, 6'b0); end
    tick();
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL alarm_quiet got %b exp %b", o, 6'b0); end
  endtask
  task automatic test_retrigger();
    logic [5:0] e;
    bus.req_click = 1'b1; tick(); bus.req_click = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = ev(tone(i), 3'd1, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL retrig_a c%0d got %b exp %b", i, o, e); end
      bus.req_click = (i == 11);
      tick();
    end
    bus.req_click = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = ev(tone(i), 3'd1, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL retrig_b c%0d got %b exp %b", i, o, e); end
      tick();
    end
    checks++; if (o !== ev(1'b0, 3'd0, 1'b1)) begin errors++; $display("FAIL retrig_done got %b exp %b", o, ev(1'b0, 3'd0, 1'b1)); end
    tick();
  endtask
  task automatic test_reset_mid();
    logic [5:0] e;
    bus.req_err = 1'b1; tick(); bus.req_err = 1'b0;
    repeat (17) tick();
    checks++; if (o !== ev(1'b0, 3'd3, 1'b0)) begin errors++; $display("FAIL mid_gap got %b exp %b", o, ev(1'b0, 3'd3, 1'b0)); end
    #1 rst = 1'b1;
    #1;
    checks++; if (o !== 6'b0) begin errors++; $display("FAIL mid_rst got %b exp %b", o, 6'b0); end
    #1 rst = 1'b0;
    bus.req_ok = 1'b1; tick(); bus.req_ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      e = ev(tone(i), 3'd2, 1'b0);
      checks++; if (o !== e) begin errors++; $display("FAIL post_ok c%0d got %b exp %b", i, o, e); end
      tick();
    end
    checks++; if (o !== ev(1'b0, 3'd0, 1'b1)) begin errors++; $display("FAIL post_done got %b exp %b", o, ev(1'b0, 3'd0, 1'b1)); end
    tick();
  endtask
  initial begin
    bus.req_click = 1'b0;
    bus.req_ok    = 1'b0;
    bus.req_err   = 1'b0;
    bus.alarm_en  = 1'b0;
    test_reset();
    test_click();
    test_err();
    test_priority();
    test_preempt();
    test_alarm();
    test_retrigger();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/buzzer_arbiter.md
# buzzer_arbiter

Sequences the single piezo buzzer output of the keypad lock among four requesters: key-click, unlock-success, wrong-code and lockout alarm. Each requester gets a fixed tone pattern (square-wave half-period, on/off segments, length). A fixed-priority arbiter with preemption decides which pattern drives the pin. The block sits between the keypad/password controller, which issues request pulses, and the `buzzer` pin.

## Interface
Parameters (all counts in `clk` cycles):
- `CNT_W`, 32, width of the duration and tone counters
- `CLICK_HALF`, 50000, click tone half-period
- `CLICK_LEN`, 10000000, click length
- `OK_HALF`, 25000, success tone half-period
- `OK_LEN`, 30000000, success length
- `ERR_HALF`, 100000, error tone half-period
- `ERR_SEG`, 5000000, error segment length (on / gap / on)
- `ALM_HALF`, 12500, alarm tone half-period
- `ALM_SEG`, 2500000, alarm on and off segment length

Ports:
- `clk` in 1: system clock, rising edge
- `RST` in 1: **one clock; reset is asynchronous and active-high**
- `req_click` in 1: one-cycle pulse, key pressed
- `req_ok` in 1: one-cycle pulse, correct code
- `req_err` in 1: one-cycle pulse, wrong code
- `alarm_en` in 1: level, lockout active
- `buzzer` out 1: piezo drive
- `busy` out 1: high in any state other than IDLE
- `tone_id` out 3: 0 idle, 1 click, 2 ok, 3 err, 4 alarm
- `done` out 1: one-cycle pulse when a click, ok or err pattern ends naturally

## Operation
- States: IDLE, CLICK, OK, ERR_ON1, ERR_GAP, ERR_ON2, ALM_ON, ALM_OFF.
- Priority: alarm > err > ok > click.
- If several requests arrive in the same cycle, the highest one wins and the rest are dropped. Requests are never queued.
- Preemption: a strictly higher-priority request aborts the current pattern and starts its own at once. The aborted pattern does not assert `done`.
- A lower-priority request while busy is dropped.
- A same-class request while busy restarts that pattern from its beginning (retrigger). An `req_err` during ERR_GAP or ERR_ON2 restarts at ERR_ON1.
- Entering any ON state (CLICK, OK, ERR_ON1, ERR_ON2, ALM_ON):
  - `buzzer` is set to 1 and both counters are cleared.
  - The tone counter counts 0..HALF-1. At HALF-1 it wraps to 0 and toggles `buzzer`, giving period 2·HALF with the high half first.
- Duration counter counts 0..LEN-1 (or SEG-1). At the terminal count the state advances on the next edge:
  - CLICK/OK → IDLE, with `done`=1.
  - ERR_ON1 → ERR_GAP → ERR_ON2 → IDLE, with `done`=1 on the ERR_ON2 exit.
  - ALM_ON ↔ ALM_OFF, repeating indefinitely.
- GAP and OFF states: `buzzer`=0 and the tone counter is held at 0.
- Rising `alarm_en` preempts everything.
- `alarm_en` low while in ALM_ON or ALM_OFF → IDLE on the next edge with `buzzer`=0 and no `done`. Pulses dropped while the alarm was active are not replayed.
- IDLE: `buzzer`=0 and the counters are held at 0.

## Timing
- Reset values: `buzzer`=0, `busy`=0, `tone_id`=0, `done`=0, state IDLE, counters 0.
- `RST` mid-pattern forces these values asynchronously. The first request after release is accepted normally.
- Latency: a request sampled at edge k gives `buzzer`=1, `busy`=1 and a valid `tone_id` immediately after edge k.
- `done` is registered and asserts in the same cycle that `busy` falls.
- A CLICK pattern occupies exactly CLICK_LEN cycles, so `busy` is high for CLICK_LEN cycles. OK is the same with OK_LEN. ERR occupies 3·ERR_SEG cycles.
- All outputs are registered with no combinational path from inputs.
- Requests arriving in the same cycle as a terminal count are evaluated against the current state, before the advance. A same-class retrigger on the terminal cycle restarts the pattern and suppresses `done`.

## Test plan
Run with HALF params = 2 and LEN/SEG params = 12.
- Reset, then a single `req_click` pulse:
  - `buzzer` reads 1,1,0,0,1,1,0,0,... for 12 cycles, then 0.
  - `tone_id`=1, `busy` high for 12 cycles, `done` pulses once on cycle 12.
- `req_err`:
  - 12 cycles of tone, then 12 cycles with `buzzer`=0 and `tone_id`=3, then 12 cycles of tone.
  - Single `done` after cycle 36.
- `req_click` and `req_ok` in the same cycle: OK plays for 12 cycles with `tone_id`=2 and the click is lost. Then `req_click` at OK cycle 5 is dropped and OK completes with `done`.
- `req_ok` playing, `req_err` at cycle 4: immediate switch to ERR_ON1 with `buzzer`=1, no `done` for OK, and the full 36-cycle error pattern follows.
- `alarm_en` high during CLICK:
  - Immediate `tone_id`=4 and ALM_ON/ALM_OFF alternating every 12 cycles.
  - `alarm_en` dropped in ALM_OFF → IDLE next edge with no `done`.
- `req_click` again at click cycle 11 → restart, `busy` high 12 more cycles, no `done` at the original end.
- `RST` pulsed mid-ERR_GAP: all outputs 0 at once; a following `req_ok` plays normally.
